prog_packet_rx: RTL and testbench

Byte-stream packet parser that builds the programming payload consumed by the renderer. Takes received bytes (from the UART receiver) and parses framed command packets. Stages the payload and commits `prog_buffer` and `is_sym_mode` only on a frame boundary, so the display never tears mid-frame. Sits between the serial receiver and the render stage in the pixel clock domain.

---
 rtl/prog_packet_rx.sv | 210 +++++++++++++++++++++
 tb/tb_prog_packet_rx.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/prog_packet_rx.sv
`default_nettype none
// ============================================================================
// prog_packet_rx : framed byte-stream parser; stages the render payload and
//                  commits it on the frame pulse (optional CHK: PROG_CHKSUM_EN)
// Rev 1.0
// ============================================================================
module prog_packet_rx #(
  parameter int PROG_PAYLD_PKT_BITS = 48,
  parameter int TIMEOUT_CYCLES      = 1_000_000
) (
  input  logic                           clk_pix,
  input  logic                           rst_pix,
  input  logic [7:0]                     rx_data,
  input  logic                           rx_valid,
  input  logic                           frame,
  output logic [PROG_PAYLD_PKT_BITS-1:0] prog_buffer,
  output logic                           is_sym_mode,
  output logic                           pkt_ok,
  output logic                           pkt_err
);

  localparam int PAYLD_BYTES = (PROG_PAYLD_PKT_BITS + 7) / 8;
  localparam int ASM_BITS    = PAYLD_BYTES * 8;
  localparam int CNT_W       = (PAYLD_BYTES > 1) ? $clog2(PAYLD_BYTES) : 1;
  localparam int TMO_W       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(PAYLD_BYTES - 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] CMD_LOAD  = 8'h01;
  localparam logic [7:0] CMD_EXIT  = 8'h02;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_PAYLD = 2'd2
`ifdef PROG_CHKSUM_EN
    , ST_CHK = 2'd3
`endif
  } state_t;

  state_t                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [ASM_BITS-1:0]            asm_q, asm_d;
  logic [PROG_PAYLD_PKT_BITS-1:0] stage_buf_q, stage_buf_d;
  logic                           stage_sym_q, stage_sym_d;
  logic                           pend_q, pend_d;
  logic [PROG_PAYLD_PKT_BITS-1:0] prog_buffer_q, prog_buffer_d;
  logic                           is_sym_mode_q, is_sym_mode_d;
  logic                           pkt_ok_q, pkt_ok_d;
  logic                           pkt_err_q, pkt_err_d;
  logic [TMO_W-1:0]               tmo_q, tmo_d;
  logic                           done;
  logic                           done_load;
`ifdef PROG_CHKSUM_EN
  logic [7:0]                     xor_q, xor_d;
  logic                           is_load_q, is_load_d;
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    asm_d         = asm_q;
    stage_buf_d   = stage_buf_q;
    stage_sym_d   = stage_sym_q;
    pend_d        = pend_q;
    prog_buffer_d = prog_buffer_q;
    is_sym_mode_d = is_sym_mode_q;
    pkt_ok_d      = 1'b0;
    pkt_err_d     = 1'b0;
    tmo_d         = tmo_q;
    done          = 1'b0;
    done_load     = 1'b0;
`ifdef PROG_CHKSUM_EN
    xor_d         = xor_q;
    is_load_d     = is_load_q;
`endif

    // Commit uses pre-edge staging; a packet completing this cycle re-arms pend below.
    if (frame && pend_q) begin
      prog_buffer_d = stage_buf_q;
      is_sym_mode_d = stage_sym_q;
      pend_d        = 1'b0;
    end

    if (rx_valid) begin
      tmo_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (rx_data == SYNC_BYTE) begin
            state_d = ST_CMD;
`ifdef PROG_CHKSUM_EN
            xor_d   = 8'h00;
`endif
          end
        end
        ST_CMD: begin
`ifdef PROG_CHKSUM_EN
          xor_d = xor_q ^ rx_data;
`endif
          if (rx_data == CMD_LOAD) begin
            state_d = ST_PAYLD;
            cnt_d   = '0;
          end else if (rx_data == CMD_EXIT) begin
`ifdef PROG_CHKSUM_EN
            state_d   = ST_CHK;
            is_load_d = 1'b0;
`else
            done      = 1'b1;
            done_load = 1'b0;
`endif
          end else begin
            pkt_err_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end
        ST_PAYLD: begin
`ifdef PROG_CHKSUM_EN
          xor_d = xor_q ^ rx_data;
`endif
          for (int i = 0; i < PAYLD_BYTES; i++) begin
            if (cnt_q == CNT_W'(i)) asm_d[i*8 +: 8] = rx_data;
          end
          if (cnt_q == LAST_IDX) begin
`ifdef PROG_CHKSUM_EN
            state_d   = ST_CHK;
            is_load_d = 1'b1;
`else
            done      = 1'b1;
            done_load = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`ifdef PROG_CHKSUM_EN
        ST_CHK: begin
          state_d = ST_IDLE;
          if (rx_data == xor_q) begin
            done      = 1'b1;
            done_load = is_load_q;
          end else begin
            pkt_err_d = 1'b1;
          end
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      if (tmo_q != TMO_LIMIT) tmo_d = tmo_q + 1'b1;
      if (tmo_d == TMO_LIMIT) begin
        pkt_err_d = 1'b1;
        state_d   = ST_IDLE;
        tmo_d     = '0;
      end
    end else begin
      tmo_d = '0;
    end

    if (done) begin
      state_d     = ST_IDLE;
      stage_sym_d = done_load;
      if (done_load) stage_buf_d = asm_d[PROG_PAYLD_PKT_BITS-1:0];
      pend_d      = 1'b1;
      pkt_ok_d    = 1'b1;
    end
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      asm_q         <= '0;
      stage_buf_q   <= '0;
      stage_sym_q   <= 1'b0;
      pend_q        <= 1'b0;
      prog_buffer_q <= '0;
      is_sym_mode_q <= 1'b0;
      pkt_ok_q      <= 1'b0;
      pkt_err_q     <= 1'b0;
      tmo_q         <= '0;
`ifdef PROG_CHKSUM_EN
      xor_q         <= 8'h00;
      is_load_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      asm_q         <= asm_d;
      stage_buf_q   <= stage_buf_d;
      stage_sym_q   <= stage_sym_d;
      pend_q        <= pend_d;
      prog_buffer_q <= prog_buffer_d;
      is_sym_mode_q <= is_sym_mode_d;
      pkt_ok_q      <= pkt_ok_d;
      pkt_err_q     <= pkt_err_d;
      tmo_q         <= tmo_d;
`ifdef PROG_CHKSUM_EN
      xor_q         <= xor_d;
      is_load_q     <= is_load_d;
`endif
    end
  end

  assign prog_buffer = prog_buffer_q;
  assign is_sym_mode = is_sym_mode_q;
  assign pkt_ok      = pkt_ok_q;
  assign pkt_err     = pkt_err_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_packet_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_prog_packet_rx : table-driven packet vectors plus directed corner cases
// Rev 1.0
// ============================================================================
module tb_prog_packet_rx;

  localparam int W   = 48;
  localparam int TMO = 16;
`ifdef PROG_CHKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic         clk_pix = 1'b0;
  logic         rst_pix = 1'b1;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_valid = 1'b0;
  logic         frame = 1'b0;
  logic [W-1:0] prog_buffer;
  logic         is_sym_mode;
  logic         pkt_ok;
  logic         pkt_err;

  int n_checks = 0;
  int n_fail   = 0;

  prog_packet_rx #(
    .PROG_PAYLD_PKT_BITS (W),
    .TIMEOUT_CYCLES      (TMO)
  ) dut (
    .clk_pix     (clk_pix),
    .rst_pix     (rst_pix),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .frame       (frame),
    .prog_buffer (prog_buffer),
    .is_sym_mode (is_sym_mode),
    .pkt_ok      (pkt_ok),
    .pkt_err     (pkt_err)
  );

  always #5 clk_pix = ~clk_pix;

  typedef struct packed {
    logic [63:0]  bytes;    // byte k at [8k+7:8k], starting with SYNC
    logic [3:0]   n;        // bytes before the checksum
    logic         add_chk;  // append computed checksum when enabled
    logic         do_frame;
    logic         exp_ok;
    logic         exp_err;
    logic [W-1:0] exp_buf;
    logic         exp_sym;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Sends bytes[0..n-1] plus checksum; optionally raises frame with the final byte.
  task automatic send_pkt(input logic [63:0] bytes, input int n, input logic add_chk,
                          input logic frame_last, input logic [7:0] corrupt);
    logic [7:0] chk;
    int         last;
    chk = 8'h00;
    for (int i = 1; i < n; i++) chk ^= bytes[i*8 +: 8];
    last = n - 1 + ((add_chk && CHK_EN) ? 1 : 0);
    for (int i = 0; i <= last; i++) begin
      @(negedge clk_pix);
      rx_valid = 1'b1;
      rx_data  = (i < n) ? bytes[i*8 +: 8] : (chk ^ corrupt);
      frame    = (i == last) ? frame_last : 1'b0;
    end
    @(negedge clk_pix);
    rx_valid = 1'b0;
    frame    = 1'b0;
  endtask

  task automatic pulse_frame;
    @(negedge clk_pix);
    frame = 1'b1;
    @(negedge clk_pix);
    frame = 1'b0;
  endtask

  task automatic check_outs(input string tag, input logic [W-1:0] eb, input logic es);
    check({tag, " prog_buffer"}, prog_buffer, eb);
    check({tag, " is_sym_mode"}, 48'(is_sym_mode), 48'(es));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{bytes: 64'h000F_0080_0040_01A5, n: 4'd8, add_chk: 1'b1, do_frame: 1'b1,
                exp_ok: 1'b1, exp_err: 1'b0, exp_buf: 48'h000F_0080_0040, exp_sym: 1'b1};
    vecs[1] = '{bytes: 64'h03A5, n: 4'd2, add_chk: 1'b0, do_frame: 1'b1,
                exp_ok: 1'b0, exp_err: 1'b1, exp_buf: 48'h000F_0080_0040, exp_sym: 1'b1};
    vecs[2] = '{bytes: 64'h02A5, n: 4'd2, add_chk: 1'b1, do_frame: 1'b1,
                exp_ok: 1'b1, exp_err: 1'b0, exp_buf: 48'h000F_0080_0040, exp_sym: 1'b0};
    vecs[3] = '{bytes: 64'h0605_0403_0201_01A5, n: 4'd8, add_chk: 1'b1, do_frame: 1'b0,
                exp_ok: 1'b1, exp_err: 1'b0, exp_buf: 48'h000F_0080_0040, exp_sym: 1'b0};
    vecs[4] = '{bytes: 64'h1615_1413_1211_01A5, n: 4'd8, add_chk: 1'b1, do_frame: 1'b1,
                exp_ok: 1'b1, exp_err: 1'b0, exp_buf: 48'h1615_1413_1211, exp_sym: 1'b1};
    vecs[5] = '{bytes: 64'h33, n: 4'd1, add_chk: 1'b0, do_frame: 1'b1,
                exp_ok: 1'b0, exp_err: 1'b0, exp_buf: 48'h1615_1413_1211, exp_sym: 1'b1};
    vecs[6] = '{bytes: 64'hA5A5_A5A5_A5A5_01A5, n: 4'd8, add_chk: 1'b1, do_frame: 1'b1,
                exp_ok: 1'b1, exp_err: 1'b0, exp_buf: 48'hA5A5_A5A5_A5A5, exp_sym: 1'b1};

    // Reset values
    repeat (3) @(negedge clk_pix);
    check_outs("reset", 48'h0, 1'b0);
    check("reset pkt_ok", 48'(pkt_ok), 48'h0);
    check("reset pkt_err", 48'(pkt_err), 48'h0);
    rst_pix = 1'b0;

    for (int v = 0; v < NV; v++) begin
      send_pkt(vecs[v].bytes, int'(vecs[v].n), vecs[v].add_chk, 1'b0, 8'h00);
      check($sformatf("v%0d pkt_ok", v), 48'(pkt_ok), 48'(vecs[v].exp_ok));
      check($sformatf("v%0d pkt_err", v), 48'(pkt_err), 48'(vecs[v].exp_err));
      @(negedge clk_pix);
      check($sformatf("v%0d pulse width", v), 48'({pkt_ok, pkt_err}), 48'h0);
      if (vecs[v].do_frame) pulse_frame();
      check_outs($sformatf("v%0d", v), vecs[v].exp_buf, vecs[v].exp_sym);
    end

`ifdef PROG_CHKSUM_EN
    // Corrupted checksum: discarded, nothing pending
    send_pkt(64'h000F_0080_0040_01A5, 8, 1'b1, 1'b0, 8'h01);
    check("badchk pkt_err", 48'(pkt_err), 48'h1);
    check("badchk pkt_ok", 48'(pkt_ok), 48'h0);
    pulse_frame();
    check_outs("badchk", 48'hA5A5_A5A5_A5A5, 1'b1);
`endif

    // Inter-byte timeout inside a LOAD
    send_pkt(64'h0040_01A5, 4, 1'b0, 1'b0, 8'h00);
    for (int k = 1; k < TMO; k++) begin
      @(negedge clk_pix);
      check($sformatf("timeout idle %0d pkt_err", k), 48'(pkt_err), 48'h0);
    end
    @(negedge clk_pix);
    check("timeout pkt_err", 48'(pkt_err), 48'h1);
    send_pkt(64'h2625_2423_2221_01A5, 8, 1'b1, 1'b0, 8'h00);
    check("after timeout pkt_ok", 48'(pkt_ok), 48'h1);
    pulse_frame();
    check_outs("after timeout", 48'h2625_2423_2221, 1'b1);

    // Completion on the frame edge with nothing pending: waits for next frame
    send_pkt(64'h3635_3433_3231_01A5, 8, 1'b1, 1'b1, 8'h00);
    check("same-cycle pkt_ok", 48'(pkt_ok), 48'h1);
    check_outs("same-cycle first frame", 48'h2625_2423_2221, 1'b1);
    pulse_frame();
    check_outs("same-cycle second frame", 48'h3635_3433_3231, 1'b1);

    // Completion on the frame edge with an older packet pending: old one commits
    send_pkt(64'h4645_4443_4241_01A5, 8, 1'b1, 1'b0, 8'h00);
    send_pkt(64'h7675_7473_7271_01A5, 8, 1'b1, 1'b1, 8'h00);
    check_outs("pre-edge staging", 48'h4645_4443_4241, 1'b1);
    pulse_frame();
    check_outs("newer after frame", 48'h7675_7473_7271, 1'b1);

    // Reset during PAYLD with a commit pending
    send_pkt(64'h5655_5453_5251_01A5, 8, 1'b1, 1'b0, 8'h00);
    send_pkt(64'h2211_01A5, 4, 1'b0, 1'b0, 8'h00);
    @(negedge clk_pix);
    rst_pix = 1'b1;
    @(negedge clk_pix);
    rst_pix = 1'b0;
    check_outs("mid reset", 48'h0, 1'b0);
    check("mid reset flags", 48'({pkt_ok, pkt_err}), 48'h0);
    pulse_frame();
    check_outs("pend lost", 48'h0, 1'b0);
    send_pkt(64'h6665_6463_6261_01A5, 8, 1'b1, 1'b0, 8'h00);
    check("post reset pkt_ok", 48'(pkt_ok), 48'h1);
    pulse_frame();
    check_outs("post reset", 48'h6665_6463_6261, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
